// File: rtl/conv_frame_collector.sv
// Re-frames valid-qualified convolution output pixels into an OUT_W x OUT_H raster with sof/eol/eof tags,
// buffered in a show-ahead FIFO. Optional feature macro: CONV_COLLECT_CHECKSUM_EN (per-frame 16-bit pixel sum).
module conv_frame_collector #(
  parameter int WORD_SIZE  = 8,
  parameter int ROW_SIZE   = 540,
  parameter int COL_SIZE   = 540,
  parameter int KERNEL_DIM = 3,
  parameter int VALID_LAG  = 3,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] pixelIn,
  input  logic [1:0]           validIn,
  output logic [WORD_SIZE-1:0] outData,
  output logic                 outSof,
  output logic                 outEol,
  output logic                 outEof,
  output logic                 outValid,
  input  logic                 outReady,
  output logic                 frameDone,
  output logic                 busy,
  output logic                 overflow
`ifdef CONV_COLLECT_CHECKSUM_EN
  ,
  output logic [15:0]          frameChecksum,
  output logic                 checksumValid
`endif
);

  localparam int OUT_W = ROW_SIZE - KERNEL_DIM + 1;
  localparam int OUT_H = COL_SIZE - KERNEL_DIM + 1;
  localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int FW    = WORD_SIZE + 3;

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  // Handshake: the head entry transfers on a cycle where outValid && outReady are both high.
  logic           w_accept;
  logic           w_unused;
  logic           w_sof, w_eol, w_eof;
  logic           w_full, w_push, w_pop;
  logic [FW-1:0]  w_head;
  logic [CW-1:0]  r_col;
  logic [RW-1:0]  r_row;
  logic [AW:0]    r_wr_ptr, r_rd_ptr;
  logic [FW-1:0]  r_mem [FIFO_DEPTH];
  state_t         r_state, w_state_nxt;
  logic           r_frame_done;
  logic           r_overflow;

  assign w_unused = validIn[1];

  // validIn[0] is delayed so that it lines up with the pixel it qualifies.
  generate
    if (VALID_LAG == 0) begin : g_no_lag
      assign w_accept = validIn[0];
    end else begin : g_lag
      logic [VALID_LAG-1:0] r_lag;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_lag <= '0;
        else      r_lag <= (r_lag << 1) | VALID_LAG'(validIn[0]);
      end
      assign w_accept = r_lag[VALID_LAG-1];
    end
  endgenerate

  assign w_sof = (r_col == '0) && (r_row == '0);
  assign w_eol = (r_col == CW'(OUT_W - 1));
  assign w_eof = w_eol && (r_row == RW'(OUT_H - 1));

  // Counters advance on every accept, even when the pixel itself is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_eol) begin
        r_col <= '0;
        r_row <= w_eof ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign outValid = (r_wr_ptr != r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop    = outValid && outReady;
  assign w_push   = w_accept && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {w_eof, w_eol, w_sof, pixelIn};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_frame_done <= w_accept && w_eof;
      if (w_accept && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign outData   = outValid ? w_head[WORD_SIZE-1:0] : '0;
  assign outSof    = outValid && w_head[WORD_SIZE];
  assign outEol    = outValid && w_head[WORD_SIZE+1];
  assign outEof    = outValid && w_head[WORD_SIZE+2];
  assign frameDone = r_frame_done;
  assign overflow  = r_overflow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state == S_ACTIVE);
    case (r_state)
      S_IDLE:   if (w_accept && !w_eof) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_accept && w_eof)  w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

`ifdef CONV_COLLECT_CHECKSUM_EN
  logic [15:0] r_sum, r_checksum, w_sum_nxt;
  logic        r_ck_valid;

  assign w_sum_nxt = r_sum + 16'(pixelIn);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum      <= '0;
      r_checksum <= '0;
      r_ck_valid <= 1'b0;
    end else begin
      r_ck_valid <= w_accept && w_eof;
      if (w_accept) begin
        if (w_eof) begin
          r_checksum <= w_sum_nxt;
          r_sum      <= '0;
        end else begin
          r_sum <= w_sum_nxt;
        end
      end
    end
  end

  assign frameChecksum = r_checksum;
  assign checksumValid = r_ck_valid;
`endif

endmodule

// File: tb/tb_conv_frame_collector.sv
// Directed bench for conv_frame_collector at OUT_W=4, OUT_H=3, VALID_LAG=3, FIFO_DEPTH=4.
module tb_conv_frame_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pixelIn;
  logic [1:0] validIn;
  logic [7:0] outData;
  logic       outSof, outEol, outEof, outValid, outReady;
  logic       frameDone, busy, overflow;
`ifdef CONV_COLLECT_CHECKSUM_EN
  logic [15:0] frameChecksum;
  logic        checksumValid;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] pix;
    logic       sof, eol, eof, busy;
  } vec_t;
  vec_t tbl [12];

  conv_frame_collector #(
    .WORD_SIZE(8), .ROW_SIZE(6), .COL_SIZE(5), .KERNEL_DIM(3), .VALID_LAG(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .pixelIn(pixelIn), .validIn(validIn),
    .outData(outData), .outSof(outSof), .outEol(outEol), .outEof(outEof),
    .outValid(outValid), .outReady(outReady), .frameDone(frameDone),
    .busy(busy), .overflow(overflow)
`ifdef CONV_COLLECT_CHECKSUM_EN
    , .frameChecksum(frameChecksum), .checksumValid(checksumValid)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(outValid), 0);
    chk({tag, "_data"},  32'(outData), 0);
    chk({tag, "_sof"},   32'(outSof), 0);
    chk({tag, "_eol"},   32'(outEol), 0);
    chk({tag, "_eof"},   32'(outEof), 0);
    chk({tag, "_fdone"}, 32'(frameDone), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_ovf"},   32'(overflow), 0);
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    validIn  = 2'b00;
    pixelIn  = 8'h55;
    outReady = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // One full 4x3 frame, stream of 12 accepts with outReady held high.
  task automatic run_frame(input string tag);
    for (int c = 0; c < 16; c++) begin
      validIn  = {1'b0, c < 12};
      pixelIn  = 8'h55;
      if (c >= 3 && c < 15) pixelIn = tbl[c-3].pix;
      outReady = 1'b1;
      step();
      if (c >= 3 && c < 15) begin
        chk({tag, "_valid"}, 32'(outValid), 1);
        chk({tag, "_data"},  32'(outData), 32'(tbl[c-3].pix));
        chk({tag, "_sof"},   32'(outSof), 32'(tbl[c-3].sof));
        chk({tag, "_eol"},   32'(outEol), 32'(tbl[c-3].eol));
        chk({tag, "_eof"},   32'(outEof), 32'(tbl[c-3].eof));
        chk({tag, "_fdone"}, 32'(frameDone), 32'(tbl[c-3].eof));
        chk({tag, "_busy"},  32'(busy), 32'(tbl[c-3].busy));
`ifdef CONV_COLLECT_CHECKSUM_EN
        if (tbl[c-3].eof) begin
          chk({tag, "_cksum"}, 32'(frameChecksum), 78);
          chk({tag, "_ckval"}, 32'(checksumValid), 1);
        end
`endif
      end
    end
    chk({tag, "_drained"}, 32'(outValid), 0);
    chk({tag, "_fdone_end"}, 32'(frameDone), 0);
  endtask

  initial begin
    tbl[0]  = '{8'd1,  1'b1, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{8'd2,  1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{8'd3,  1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{8'd4,  1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{8'd5,  1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{8'd6,  1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{8'd7,  1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{8'd8,  1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{8'd9,  1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{8'd10, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{8'd11, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{8'd12, 1'b0, 1'b1, 1'b1, 1'b0};

    do_reset();
    chk_all_zero("rst");

    run_frame("frame");

    // Lag alignment: only the pixel three cycles after the qualifier is taken.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      validIn  = {1'b0, c == 0};
      pixelIn  = (c == 3) ? 8'hAA : 8'h55;
      outReady = 1'b0;
      step();
      if (c == 2) chk("lag_early", 32'(outValid), 0);
    end
    chk("lag_valid", 32'(outValid), 1);
    chk("lag_data",  32'(outData), 32'h0AA);
    chk("lag_sof",   32'(outSof), 1);

    // Overflow: five accepts into a 4-deep FIFO with no consumer.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      validIn  = {1'b0, c < 5};
      pixelIn  = (c >= 3) ? 8'(c - 2) : 8'h55;
      outReady = 1'b0;
      step();
      if (c == 6) chk("ovf_before", 32'(overflow), 0);
    end
    chk("ovf_set",  32'(overflow), 1);
    chk("ovf_head", 32'(outData), 1);
    validIn  = 2'b00;
    outReady = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      step();
      if (k <= 4) chk("ovf_pop", 32'(outData), 32'(k));
      else        chk("ovf_empty", 32'(outValid), 0);
    end
    chk("ovf_sticky", 32'(overflow), 1);
    for (int c = 0; c < 6; c++) begin
      validIn = {1'b0, c < 3};
      pixelIn = (c >= 3) ? 8'(c + 3) : 8'h55;
      step();
      if (c >= 3) begin
        chk("ovf_next_data", 32'(outData), 32'(c + 3));
        chk("ovf_next_eol",  32'(outEol), 32'(c == 5));
        chk("ovf_next_sof",  32'(outSof), 0);
      end
    end

    // Full FIFO with simultaneous accept and pop.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      validIn  = {1'b0, c < 5};
      pixelIn  = (c >= 3) ? 8'(c - 2) : 8'h55;
      outReady = (c == 7);
      step();
    end
    outReady = 1'b0;
    validIn  = 2'b00;
    chk("full_ovf",  32'(overflow), 0);
    chk("full_head", 32'(outData), 2);
    outReady = 1'b1;
    for (int k = 3; k <= 6; k++) begin
      step();
      if (k <= 5) chk("full_pop", 32'(outData), 32'(k));
      else        chk("full_empty", 32'(outValid), 0);
    end

    // Asynchronous reset in the middle of a frame, then a clean frame.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      validIn  = 2'b01;
      pixelIn  = (c >= 3) ? 8'(c - 2) : 8'h55;
      outReady = 1'b1;
      step();
    end
    chk("mid_busy", 32'(busy), 1);
    #2 rst = 1'b0;
    #1;
    chk_all_zero("async");
    validIn = 2'b00;
    step();
    step();
    rst = 1'b1;
    run_frame("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
